// File: rtl/div_reconstructor.sv
// Shift-add dividend rebuilder: product = quo * divisor + rem, plus a legality flag.
// Optional macro DIV_RECON_EARLY_EXIT_EN ends the run once the remaining quotient bits are zero.
module div_reconstructor #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     quo,
  input  logic [WIDTH-1:0]     divisor,
  input  logic [WIDTH-1:0]     rem,
  output logic [2*WIDTH-1:0]   product,
  output logic                 err,
  output logic                 busy,
  output logic                 done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [WIDTH-1:0]   q_sh_q, q_sh_d;
  logic [2*WIDTH-1:0] m_sh_q, m_sh_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_n_q, err_n_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic               err_q, err_d;
  logic               done_q, done_d;

  logic [2*WIDTH-1:0] acc_sum;
  logic               last_iter;

  always_comb begin
    state_d   = state_q;
    q_sh_d    = q_sh_q;
    m_sh_d    = m_sh_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    err_n_d   = err_n_q;
    product_d = product_q;
    err_d     = err_q;
    done_d    = 1'b0;
    acc_sum   = acc_q;
    last_iter = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          q_sh_d  = quo;
          m_sh_d  = {{WIDTH{1'b0}}, divisor};
          acc_d   = {{WIDTH{1'b0}}, rem};
          cnt_d   = '0;
          err_n_d = (divisor == '0) || (rem >= divisor);
          state_d = RUN;
        end
      end
      default: begin
        // The sum cannot exceed (2^W-1)^2 + 2^W-1, so 2W bits always suffice.
        acc_sum   = q_sh_q[0] ? (acc_q + m_sh_q) : acc_q;
        acc_d     = acc_sum;
        m_sh_d    = m_sh_q << 1;
        q_sh_d    = q_sh_q >> 1;
        cnt_d     = cnt_q + 1'b1;
        last_iter = (cnt_q == CNT_W'(WIDTH - 1));
`ifdef DIV_RECON_EARLY_EXIT_EN
        if (q_sh_d == '0) begin
          last_iter = 1'b1;
        end
`endif
        if (last_iter) begin
          product_d = acc_sum;
          err_d     = err_n_q;
          done_d    = 1'b1;
          state_d   = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      q_sh_q    <= '0;
      m_sh_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      err_n_q   <= 1'b0;
      product_q <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      q_sh_q    <= q_sh_d;
      m_sh_q    <= m_sh_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      err_n_q   <= err_n_d;
      product_q <= product_d;
      err_q     <= err_d;
      done_q    <= done_d;
    end
  end

  assign product = product_q;
  assign err     = err_q;
  assign done    = done_q;
  assign busy    = (state_q == RUN);

endmodule

// File: tb/tb_div_reconstructor.sv
// Directed self-checking bench for div_reconstructor; honours DIV_RECON_EARLY_EXIT_EN for latency.
module tb_div_reconstructor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] quo, divisor, rem;
  logic [7:0] product;
  logic       err, busy, done;

  int checks = 0;
  int errors = 0;

  div_reconstructor #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .quo(quo), .divisor(divisor), .rem(rem),
    .product(product), .err(err), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_lat(input logic [3:0] q);
    int lat;
    lat = 4;
`ifdef DIV_RECON_EARLY_EXIT_EN
    lat = 1;
    for (int i = 0; i < 4; i++) if (q[i]) lat = i + 1;
`endif
    return lat;
  endfunction

  // Launch one operation, wait (bounded) for done, check result, latency and pulse width.
  task automatic run_op(input string tag, input logic [3:0] q, input logic [3:0] d,
                        input logic [3:0] r, input logic [7:0] exp_p, input logic exp_e);
    int cyc;
    @(negedge clk);
    quo = q; divisor = d; rem = r; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; quo = 4'hF; divisor = 4'hF; rem = 4'hF;
    chk({tag, "_busy_start"}, busy, 1);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!done && cyc < 20);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_latency"}, cyc, exp_lat(q));
    chk({tag, "_product"}, product, exp_p);
    chk({tag, "_err"}, err, exp_e);
    chk({tag, "_busy_at_done"}, busy, 0);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_product_held"}, product, exp_p);
  endtask

  initial begin
    int n_done;
    logic [7:0] first_p;
    logic       first_e;
    rst = 1'b1; start = 1'b0; quo = '0; divisor = '0; rem = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_product", product, 0);
    chk("reset_err", err, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);

    run_op("basic", 4'd3, 4'd4, 4'd1, 8'd13, 1'b0);
    run_op("maxval", 4'd15, 4'd15, 4'd14, 8'd239, 1'b0);
    run_op("div0", 4'd5, 4'd0, 4'd3, 8'd3, 1'b1);

    // A second start two cycles into an operation must be dropped.
    @(negedge clk);
    quo = 4'd7; divisor = 4'd5; rem = 4'd2; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    chk("ignore_busy1", busy, 1);
    quo = 4'd1; divisor = 4'd1; rem = 4'd0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("ignore_busy2", busy, 1);
    n_done = 0; first_p = '0; first_e = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (done) begin
        if (n_done == 0) begin first_p = product; first_e = err; end
        n_done++;
      end
      @(posedge clk); #1;
    end
    chk("ignore_done_count", n_done, 1);
    chk("ignore_product", first_p, 37);
    chk("ignore_err", first_e, 0);

    run_op("remge", 4'd2, 4'd3, 4'd3, 8'd9, 1'b1);

    // Reset mid-operation, with a start in the reset cycle.
    @(negedge clk);
    quo = 4'd3; divisor = 4'd4; rem = 4'd1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 rst = 1'b1; start = 1'b1;
    @(posedge clk); #1 rst = 1'b0; start = 1'b0;
    chk("abort_product", product, 0);
    chk("abort_err", err, 0);
    chk("abort_busy", busy, 0);
    n_done = 0;
    for (int i = 0; i < 6; i++) begin
      if (done || busy) n_done++;
      @(posedge clk); #1;
    end
    chk("abort_no_activity", n_done, 0);
    run_op("after_abort", 4'd6, 4'd2, 4'd1, 8'd13, 1'b0);

    run_op("early_q1", 4'd1, 4'd7, 4'd2, 8'd9, 1'b0);
    run_op("early_q0", 4'd0, 4'd7, 4'd5, 8'd5, 1'b0);

    // Back-to-back with start held high.
    @(negedge clk);
    quo = 4'd2; divisor = 4'd5; rem = 4'd1; start = 1'b1;
    n_done = 0;
    do begin
      @(posedge clk); #1;
      n_done++;
    end while (!done && n_done < 20);
    chk("b2b_first_product", product, 11);
    chk("b2b_busy_low_at_done", busy, 0);
    quo = 4'd3; divisor = 4'd3; rem = 4'd0;
    @(posedge clk); #1;
    chk("b2b_restart_busy", busy, 1);
    start = 1'b0;
    n_done = 0;
    do begin
      @(posedge clk); #1;
      n_done++;
    end while (!done && n_done < 20);
    chk("b2b_second_done", done, 1);
    chk("b2b_second_product", product, 9);
    chk("b2b_second_err", err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_reconstructor.md
# div_reconstructor

Sequential shift-add block that rebuilds the dividend from a divider result: product = quo × divisor + rem. It sits on the result side of the 4-bit non-restoring divider in the bootcamp datapath and runs as a self-checking companion. Its output is compared against the original dividend, and it also flags results that cannot be legal (remainder not below the divisor, or zero divisor).

## Interface
- WIDTH, 4: operand width in bits; product is 2×WIDTH bits.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset; has priority over every other input.
- start  in  1  request; sampled only while idle (busy=0).
- quo  in  WIDTH  quotient, unsigned; captured on the accepted start.
- divisor  in  WIDTH  divisor, unsigned; captured on the accepted start.
- rem  in  WIDTH  remainder, unsigned; captured on the accepted start.
- product  out  2×WIDTH  reconstructed dividend; holds its value until the next completion or rst.
- err  out  1  updated together with product; 1 if divisor==0 or rem>=divisor.
- busy  out  1  high while an operation is in progress.
- done  out  1  single-cycle pulse, high in the cycle when product/err become valid.

## Operation
- States: IDLE, RUN.
- IDLE:
  - If start=1 at an edge, capture operands:
    - q_sh = quo
    - m_sh = zero-extended divisor (2×WIDTH bits)
    - acc = zero-extended rem
    - cnt = 0
    - err_n = (divisor==0) || (rem>=divisor)
  - Move to RUN; busy=1 from the next cycle.
- RUN, each edge:
  - If q_sh[0]==1, acc = acc + m_sh; the add is 2×WIDTH bits wide and never overflows, since the maximum is (2^W−1)^2 + 2^W−1 < 2^(2W).
  - Then m_sh shifts left by 1, q_sh shifts right by 1, cnt increments.
- Termination:
  - After the iteration with cnt==WIDTH−1, at the same edge:
    - product = final acc
    - err = err_n
    - done = 1 for exactly one cycle
    - busy = 0
    - state = IDLE
- Calculation is always carried out, even when err is raised.
- start while busy=1 is ignored, with no queuing.
- start held high continuously gives back-to-back operations. The cycle after done has busy=0, and a new start is accepted on that edge.
- Operand inputs may change freely after the capture edge.

## Timing
- Reset values: product=0, err=0, busy=0, done=0, state=IDLE, cnt=0, acc=0.
- rst asserted mid-operation aborts it:
  - no done pulse
  - product/err cleared
  - start in the same cycle as rst is discarded
- Latency without the macro (start accepted at edge E):
  - busy=1 in the cycles after edges E … E+WIDTH−1
  - product/done valid after edge E+WIDTH
  - fixed WIDTH cycles
- Throughput: one operation per WIDTH+1 cycles with start held high.
- done and product update on the same edge; the consumer samples product when done=1.

## Configuration
- DIV_RECON_EARLY_EXIT_EN defined:
  - RUN also terminates after any iteration where the shifted q_sh becomes 0.
  - Latency = max(1, position of highest set bit of quo + 1) cycles; quo=0 completes in 1 cycle with product=rem.
  - Results are identical to the non-macro build.
- Not defined: fixed WIDTH-cycle latency, independent of quo.

## Test plan
- WIDTH=4, quo=3, divisor=4, rem=1 -> product=13, err=0, done exactly 4 cycles after start edge, single-cycle pulse.
- quo=15, divisor=15, rem=14 -> product=239, err=0; max-value check with no overflow.
- divisor=0, quo=5, rem=3 -> product=3, err=1. Then quo=2, divisor=3, rem=3 -> product=9, err=1.
- start pulsed again 2 cycles into an operation with different operands -> ignored; first result delivered unchanged, busy stays high, one done only.
- rst high for one cycle at cycle 2 of an operation -> no done; product=0, busy=0, err=0 next cycle. A subsequent start of 6,2,1 -> product=13.
- With DIV_RECON_EARLY_EXIT_EN: quo=1, divisor=7, rem=2 -> product=9, done 1 cycle after start edge. quo=0, rem=5 -> product=5 in 1 cycle. Without macro, both take 4 cycles.
